// File: rtl/bpm_link_stats_if.sv
// rtl/bpm_link_stats_if.sv - link reader to statistics block strobe/payload bundle
//
// Signals:
//   statusStrobe  one-cycle pulse, statusCode valid
//   statusCode    0 success, 1 bad header, 2 bad size, 3 bad packet
//   outputStrobe  one-cycle pulse, outputData valid (good packet)
//   outputData    [111:96] header low half, [95:64] X, [63:32] Y, [31:0] S
// Modports:
//   master  link reader side (drives)
//   slave   statistics side (samples)

interface bpm_link_stats_if;
    logic         statusStrobe;
    logic [1:0]   statusCode;
    logic         outputStrobe;
    logic [111:0] outputData;

    modport master (
        output statusStrobe,
        output statusCode,
        output outputStrobe,
        output outputData
    );

    modport slave (
        input statusStrobe,
        input statusCode,
        input outputStrobe,
        input outputData
    );
endinterface

// File: rtl/bpm_link_stats.sv
// rtl/bpm_link_stats.sv - per-link reception statistics and link-health monitor
//
// Parameters:
//   COUNT_WIDTH     width of every event counter
//   TIMEOUT_CYCLES  status-free cycles after which an up link goes down (>=2)
//   ERR_LIMIT       consecutive non-success statuses that force an up link down (1..15)
// Ports:
//   clk             Aurora receiver AXI clock
//   rst_n           asynchronous active-low reset
//   link            slave side of the reader strobe/payload bundle
//   snapshotStrobe  one-cycle pulse: latch and clear live counters
//   snapSuccess, snapBadHeader, snapBadSize, snapBadPacket  latched per-code counts
//   snapLinkDowns   latched up->down transition count
//   snapValid       high from the first snapshot onward
//   lastHeader      outputData[111:96] of most recent good packet
//   linkUp          current link state

module bpm_link_stats #(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 156250,
    parameter int ERR_LIMIT      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bpm_link_stats_if.slave        link,
    input  logic                   snapshotStrobe,
    output logic [COUNT_WIDTH-1:0] snapSuccess,
    output logic [COUNT_WIDTH-1:0] snapBadHeader,
    output logic [COUNT_WIDTH-1:0] snapBadSize,
    output logic [COUNT_WIDTH-1:0] snapBadPacket,
    output logic [COUNT_WIDTH-1:0] snapLinkDowns,
    output logic                   snapValid,
    output logic [15:0]            lastHeader,
    output logic                   linkUp
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0]      IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]             ERR_MAX  = 4'(ERR_LIMIT);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_SAT  = {COUNT_WIDTH{1'b1}};

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } state_t;

    state_t                  state;
    logic [COUNT_WIDTH-1:0]  live_cnt [4];
    logic [COUNT_WIDTH-1:0]  snap_cnt [4];
    logic [COUNT_WIDTH-1:0]  live_downs;
    logic [COUNT_WIDTH-1:0]  snap_downs;
    logic [IDLE_W-1:0]       idle_cnt;
    logic [3:0]              err_run;
    logic                    snap_valid_q;
    logic [15:0]             last_header_q;

    logic                    is_success;
    logic                    is_error;
    logic                    err_hit;
    logic                    timeout_hit;
    logic                    link_drop;
    logic                    link_rise;
    logic [3:0]              code_hit;

    // Only the header half of the payload is of interest here.
    logic unused_payload;
    assign unused_payload = ^link.outputData[95:0];

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        is_success  = link.statusStrobe && (link.statusCode == 2'd0);
        is_error    = link.statusStrobe && (link.statusCode != 2'd0);
        // Widened compare so a run already at 15 cannot wrap into a false miss.
        err_hit     = is_error && (({1'b0, err_run} + 5'd1) >= {1'b0, ERR_MAX});
        // A strobe in the terminal-count cycle clears idle and beats the timeout.
        timeout_hit = !link.statusStrobe && (idle_cnt == IDLE_MAX);
        link_drop   = (state == ST_UP) && (timeout_hit || err_hit);
        link_rise   = (state == ST_DOWN) && is_success;
        for (int i = 0; i < 4; i++) begin
            code_hit[i] = link.statusStrobe && (link.statusCode == 2'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_DOWN;
            live_downs    <= '0;
            snap_downs    <= '0;
            idle_cnt      <= '0;
            err_run       <= '0;
            snap_valid_q  <= 1'b0;
            last_header_q <= '0;
            for (int i = 0; i < 4; i++) begin
                live_cnt[i] <= '0;
                snap_cnt[i] <= '0;
            end
        end else begin
            // Link state
            if (link_drop) begin
                state <= ST_DOWN;
            end else if (link_rise) begin
                state <= ST_UP;
            end

            // Idle tracker saturates so a long-dead link never re-fires.
            if (link.statusStrobe) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (is_success) begin
                err_run <= '0;
            end else if (is_error && (err_run < ERR_MAX)) begin
                err_run <= err_run + 4'd1;
            end

            // Coincident snapshot: snap gets the pre-event value and the
            // event opens the new interval.
            for (int i = 0; i < 4; i++) begin
                if (snapshotStrobe) begin
                    snap_cnt[i] <= live_cnt[i];
                    live_cnt[i] <= code_hit[i] ? CNT_ONE : '0;
                end else if (code_hit[i]) begin
                    live_cnt[i] <= sat_inc(live_cnt[i]);
                end
            end

            if (snapshotStrobe) begin
                snap_downs   <= live_downs;
                live_downs   <= link_drop ? CNT_ONE : '0;
                snap_valid_q <= 1'b1;
            end else if (link_drop) begin
                live_downs <= sat_inc(live_downs);
            end

            if (link.outputStrobe) begin
                last_header_q <= link.outputData[111:96];
            end
        end
    end

    assign snapSuccess   = snap_cnt[0];
    assign snapBadHeader = snap_cnt[1];
    assign snapBadSize   = snap_cnt[2];
    assign snapBadPacket = snap_cnt[3];
    assign snapLinkDowns = snap_downs;
    assign snapValid     = snap_valid_q;
    assign lastHeader    = last_header_q;
    assign linkUp        = (state == ST_UP);

endmodule

// File: tb/tb_bpm_link_stats.sv
// tb/tb_bpm_link_stats.sv - directed self-checking bench for bpm_link_stats

module tb_bpm_link_stats;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          snapshotStrobe;
    logic [CW-1:0] snapSuccess, snapBadHeader, snapBadSize, snapBadPacket, snapLinkDowns;
    logic          snapValid;
    logic [15:0]   lastHeader;
    logic          linkUp;

    int total = 0;
    int bad   = 0;

    bpm_link_stats_if link_if ();

    bpm_link_stats #(
        .COUNT_WIDTH    (CW),
        .TIMEOUT_CYCLES (10),
        .ERR_LIMIT      (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .link           (link_if.slave),
        .snapshotStrobe (snapshotStrobe),
        .snapSuccess    (snapSuccess),
        .snapBadHeader  (snapBadHeader),
        .snapBadSize    (snapBadSize),
        .snapBadPacket  (snapBadPacket),
        .snapLinkDowns  (snapLinkDowns),
        .snapValid      (snapValid),
        .lastHeader     (lastHeader),
        .linkUp         (linkUp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes held, sampled 1 time unit after the edge.
    task automatic step(input logic ss, input logic [1:0] sc, input logic snap);
        link_if.statusStrobe = ss;
        link_if.statusCode   = sc;
        snapshotStrobe       = snap;
        @(posedge clk);
        #1;
        link_if.statusStrobe = 1'b0;
        link_if.statusCode   = 2'd0;
        snapshotStrobe       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        logic [1:0] codes [8];
        codes = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};

        rst_n                = 1'b0;
        snapshotStrobe       = 1'b0;
        link_if.statusStrobe = 1'b0;
        link_if.statusCode   = 2'd0;
        link_if.outputStrobe = 1'b0;
        link_if.outputData   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_linkUp", 32'(linkUp), 32'd0);
        chk("reset_snapValid", 32'(snapValid), 32'd0);
        chk("reset_lastHeader", 32'(lastHeader), 32'd0);
        chk("reset_snapSuccess", 32'(snapSuccess), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three successes then snapshot
        step(1'b1, 2'd0, 1'b0);
        chk("up_after_first_success", 32'(linkUp), 32'd1);
        step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b1);
        chk("snap1_success", 32'(snapSuccess), 32'd3);
        chk("snap1_badheader", 32'(snapBadHeader), 32'd0);
        chk("snap1_badsize", 32'(snapBadSize), 32'd0);
        chk("snap1_badpacket", 32'(snapBadPacket), 32'd0);
        chk("snap1_downs", 32'(snapLinkDowns), 32'd0);
        chk("snap1_valid", 32'(snapValid), 32'd1);

        // Timeout: 10 strobe-free cycles after a success
        step(1'b1, 2'd0, 1'b0);
        idle(9);
        chk("timeout_still_up_9", 32'(linkUp), 32'd1);
        idle(1);
        chk("timeout_down_10", 32'(linkUp), 32'd0);
        step(1'b0, 2'd0, 1'b1);
        chk("snap2_downs", 32'(snapLinkDowns), 32'd1);
        chk("snap2_success", 32'(snapSuccess), 32'd1);

        // Strobe on the 10th cycle keeps the link up
        step(1'b1, 2'd0, 1'b0);
        idle(9);
        step(1'b1, 2'd0, 1'b0);
        chk("strobe_on_tc_keeps_up", 32'(linkUp), 32'd1);
        step(1'b0, 2'd0, 1'b1);
        chk("snap3_success", 32'(snapSuccess), 32'd2);
        chk("snap3_downs", 32'(snapLinkDowns), 32'd0);

        // Error run: only the final code 3 reaches ERR_LIMIT
        for (int i = 0; i < 7; i++) step(1'b1, codes[i], 1'b0);
        chk("err_still_up", 32'(linkUp), 32'd1);
        step(1'b1, codes[7], 1'b0);
        chk("err_down", 32'(linkUp), 32'd0);
        step(1'b0, 2'd0, 1'b1);
        chk("snap4_badheader", 32'(snapBadHeader), 32'd4);
        chk("snap4_badsize", 32'(snapBadSize), 32'd1);
        chk("snap4_badpacket", 32'(snapBadPacket), 32'd2);
        chk("snap4_success", 32'(snapSuccess), 32'd1);
        chk("snap4_downs", 32'(snapLinkDowns), 32'd1);

        // Saturation at COUNT_WIDTH=4
        for (int i = 0; i < 20; i++) step(1'b1, 2'd1, 1'b0);
        chk("sat_link_down", 32'(linkUp), 32'd0);
        step(1'b0, 2'd0, 1'b1);
        chk("sat_badheader", 32'(snapBadHeader), 32'd15);
        step(1'b0, 2'd0, 1'b1);
        chk("sat_second_snap", 32'(snapBadHeader), 32'd0);
        chk("sat_valid_sticky", 32'(snapValid), 32'd1);

        // Snapshot coincident with the 6th success
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 1'b0);
        step(1'b1, 2'd0, 1'b1);
        chk("coinc_snap_success", 32'(snapSuccess), 32'd5);
        step(1'b0, 2'd0, 1'b1);
        chk("coinc_next_success", 32'(snapSuccess), 32'd1);

        // lastHeader then asynchronous reset mid-stream
        link_if.outputStrobe = 1'b1;
        link_if.outputData   = {16'h1234, 32'hdeadbeef, 32'h01020304, 32'h0a0b0c0d};
        @(posedge clk);
        #1;
        link_if.outputStrobe = 1'b0;
        link_if.outputData   = '0;
        chk("last_header", 32'(lastHeader), 32'h1234);
        chk("pre_reset_up", 32'(linkUp), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_header", 32'(lastHeader), 32'd0);
        chk("async_rst_linkUp", 32'(linkUp), 32'd0);
        chk("async_rst_valid", 32'(snapValid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b1);
        chk("post_rst_success", 32'(snapSuccess), 32'd1);
        chk("post_rst_up", 32'(linkUp), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
